// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour codes for the timing generator and sprite blocks.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int SCALE_SHIFT = 2;
    localparam int GAME_W      = 160;
    localparam int GAME_H      = 120;

    localparam int COLOR_W = 3;
    typedef logic [COLOR_W-1:0] color_t;

    // Colour codes are {R,G,B}; display_sprite stores sprite pixels in this encoding.
    typedef enum logic [COLOR_W-1:0] {
        COL_BLACK   = 3'b000,
        COL_BLUE    = 3'b001,
        COL_GREEN   = 3'b010,
        COL_CYAN    = 3'b011,
        COL_RED     = 3'b100,
        COL_MAGENTA = 3'b101,
        COL_YELLOW  = 3'b110,
        COL_WHITE   = 3'b111
    } color_code_e;

    function automatic logic [9:0] scale_down(input logic [9:0] native, input int shift);
        return native >> shift;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-coordinate bus between the timing generator (master) and the sprite/compositor (slave).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [7:0] xvga;
    logic [6:0] yvga;
    logic       pix_active;
    logic       frame_start;
    color_t     color_in;

    modport master (
        output xvga,
        output yvga,
        output pix_active,
        output frame_start,
        input  color_in
    );

    modport slave (
        input  xvga,
        input  yvga,
        input  pix_active,
        input  frame_start,
        output color_in
    );

endinterface

// File: rtl/sync_delay_line.sv
// Single-bit shift register used to delay-match sync/active with the compositor pipeline.
module sync_delay_line #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= {DEPTH{RESET_VAL}};
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator issuing 160x120 game coordinates and delay-matched sync/RGB.
module vga_timing_gen #(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter int PIPE_DELAY  = 1
) (
    input  logic                VGA_CLK,
    input  logic                reset,
    vga_timing_gen_if.master    vif,
    output logic                vga_hs,
    output logic                vga_vs,
    output vga_pkg::color_t     vga_rgb
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       h_vis;
    logic       v_vis;
    logic       active_raw;
    logic       hs_raw;
    logic       vs_raw;
    logic       hs_dly;
    logic       vs_dly;
    logic       act_dly;

    // Raster counters; the frame wrap happens on the same edge as the last line wrap.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // Coordinates are decoded straight from the counters so the compositor sees them with no lag;
    // gating with reset keeps the bus quiet while the counters sit at (0,0).
    always_comb begin
        h_vis      = (hcount < H_VIS_END);
        v_vis      = (vcount < V_VIS_END);
        active_raw = h_vis && v_vis && !reset;
        hs_raw     = !((hcount >= HS_START) && (hcount < HS_END));
        vs_raw     = !((vcount >= VS_START) && (vcount < VS_END));

        vif.xvga        = h_vis ? 8'(scale_down(hcount, SCALE_SHIFT)) : 8'd0;
        vif.yvga        = v_vis ? 7'(scale_down(vcount, SCALE_SHIFT)) : 7'd0;
        vif.pix_active  = active_raw;
        vif.frame_start = (hcount == 10'd0) && (vcount == 10'd0) && !reset;
    end

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(1'b1)) u_hs_dly (
        .clk  (VGA_CLK),
        .rst  (reset),
        .din  (hs_raw),
        .dout (hs_dly)
    );

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(1'b1)) u_vs_dly (
        .clk  (VGA_CLK),
        .rst  (reset),
        .din  (vs_raw),
        .dout (vs_dly)
    );

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(1'b0)) u_act_dly (
        .clk  (VGA_CLK),
        .rst  (reset),
        .din  (active_raw),
        .dout (act_dly)
    );

    // Output stage: colour for a blanked coordinate is dropped so the DAC sees black in the porches.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_rgb <= '0;
        end else begin
            vga_hs  <= hs_dly;
            vga_vs  <= vs_dly;
            vga_rgb <= act_dly ? vif.color_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing with PIPE_DELAY 1 and 3, plus a shrunken raster for frame-level checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam logic [2:0] COLOR = 3'b101;

    // Shrunken raster: 24 clocks per line, 14 lines per frame.
    localparam int S_HA = 16, S_HFP = 2, S_HSYNC = 4, S_HBP = 2;
    localparam int S_VA = 8,  S_VFP = 2, S_VSYNC = 2, S_VBP = 2;
    localparam int S_HTOT = S_HA + S_HFP + S_HSYNC + S_HBP;
    localparam int S_VTOT = S_VA + S_VFP + S_VSYNC + S_VBP;

    logic VGA_CLK = 1'b0;
    logic rst_ab;
    logic rst_s;

    always #5 VGA_CLK = ~VGA_CLK;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_s ();

    logic       hs_a, vs_a, hs_b, vs_b, hs_s, vs_s;
    logic [2:0] rgb_a, rgb_b, rgb_s;

    vga_timing_gen #(.PIPE_DELAY(1)) dut_a (
        .VGA_CLK (VGA_CLK),
        .reset   (rst_ab),
        .vif     (if_a.master),
        .vga_hs  (hs_a),
        .vga_vs  (vs_a),
        .vga_rgb (rgb_a)
    );

    vga_timing_gen #(.PIPE_DELAY(3)) dut_b (
        .VGA_CLK (VGA_CLK),
        .reset   (rst_ab),
        .vif     (if_b.master),
        .vga_hs  (hs_b),
        .vga_vs  (vs_b),
        .vga_rgb (rgb_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
        .SCALE_SHIFT(2), .PIPE_DELAY(1)
    ) dut_s (
        .VGA_CLK (VGA_CLK),
        .reset   (rst_s),
        .vif     (if_s.master),
        .vga_hs  (hs_s),
        .vga_vs  (vs_s),
        .vga_rgb (rgb_s)
    );

    int pass_count  = 0;
    int check_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ab, input logic s, input logic [2:0] col);
        rst_ab         = ab;
        rst_s          = s;
        if_a.color_in  = col;
        if_b.color_in  = col;
        if_s.color_in  = col;
    endtask

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    // Reference raster: c is the number of clocks since reset release.
    function automatic logic ref_vis(int c, int htot, int vtot, int ha, int va);
        return ((c % htot) < ha) && (((c / htot) % vtot) < va);
    endfunction

    function automatic logic ref_hs(int c, int d, int htot, int hstart, int hsync);
        int p;
        p = c - d - 1;
        if (p < 0) return 1'b1;
        return !(((p % htot) >= hstart) && ((p % htot) < hstart + hsync));
    endfunction

    function automatic logic ref_vs(int c, int d, int htot, int vtot, int vstart, int vsync);
        int p;
        p = c - d - 1;
        if (p < 0) return 1'b1;
        return !((((p / htot) % vtot) >= vstart) && (((p / htot) % vtot) < vstart + vsync));
    endfunction

    function automatic logic [2:0] ref_rgb(int c, int d, int htot, int vtot, int ha, int va);
        int p;
        p = c - d - 1;
        if (p < 0) return 3'b000;
        return ref_vis(p, htot, vtot, ha, va) ? COLOR : 3'b000;
    endfunction

    task automatic checkAB(input int c);
        int h, v;
        h = c % 800;
        v = (c / 800) % 525;
        checkOutput($sformatf("a.xvga@%0d", c), 32'(if_a.xvga), (h < 640) ? 32'(h >> 2) : 32'd0);
        checkOutput($sformatf("a.yvga@%0d", c), 32'(if_a.yvga), (v < 480) ? 32'(v >> 2) : 32'd0);
        checkOutput($sformatf("a.pix_active@%0d", c), 32'(if_a.pix_active), 32'(ref_vis(c, 800, 525, 640, 480)));
        checkOutput($sformatf("a.frame_start@%0d", c), 32'(if_a.frame_start), 32'(h == 0 && v == 0));
        checkOutput($sformatf("a.hs@%0d", c), 32'(hs_a), 32'(ref_hs(c, 1, 800, 656, 96)));
        checkOutput($sformatf("a.vs@%0d", c), 32'(vs_a), 32'(ref_vs(c, 1, 800, 525, 490, 2)));
        checkOutput($sformatf("a.rgb@%0d", c), 32'(rgb_a), 32'(ref_rgb(c, 1, 800, 525, 640, 480)));
        checkOutput($sformatf("b.hs@%0d", c), 32'(hs_b), 32'(ref_hs(c, 3, 800, 656, 96)));
        checkOutput($sformatf("b.rgb@%0d", c), 32'(rgb_b), 32'(ref_rgb(c, 3, 800, 525, 640, 480)));
    endtask

    task automatic checkS(input int c);
        int h, v;
        h = c % S_HTOT;
        v = (c / S_HTOT) % S_VTOT;
        checkOutput($sformatf("s.xvga@%0d", c), 32'(if_s.xvga), (h < S_HA) ? 32'(h >> 2) : 32'd0);
        checkOutput($sformatf("s.yvga@%0d", c), 32'(if_s.yvga), (v < S_VA) ? 32'(v >> 2) : 32'd0);
        checkOutput($sformatf("s.pix_active@%0d", c), 32'(if_s.pix_active), 32'(ref_vis(c, S_HTOT, S_VTOT, S_HA, S_VA)));
        checkOutput($sformatf("s.frame_start@%0d", c), 32'(if_s.frame_start), 32'(h == 0 && v == 0));
        checkOutput($sformatf("s.hs@%0d", c), 32'(hs_s), 32'(ref_hs(c, 1, S_HTOT, S_HA + S_HFP, S_HSYNC)));
        checkOutput($sformatf("s.vs@%0d", c), 32'(vs_s), 32'(ref_vs(c, 1, S_HTOT, S_VTOT, S_VA + S_VFP, S_VSYNC)));
        checkOutput($sformatf("s.rgb@%0d", c), 32'(rgb_s), 32'(ref_rgb(c, 1, S_HTOT, S_VTOT, S_HA, S_VA)));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".s.pix_active"},  32'(if_s.pix_active),  32'd0);
        checkOutput({tag, ".s.frame_start"}, 32'(if_s.frame_start), 32'd0);
        checkOutput({tag, ".s.xvga"},        32'(if_s.xvga),        32'd0);
        checkOutput({tag, ".s.yvga"},        32'(if_s.yvga),        32'd0);
        checkOutput({tag, ".s.hs"},          32'(hs_s),             32'd1);
        checkOutput({tag, ".s.vs"},          32'(vs_s),             32'd1);
        checkOutput({tag, ".s.rgb"},         32'(rgb_s),            32'd0);
    endtask

    initial begin
        int hs_a_low;
        int rgb_a_lit;
        int first_b_low;
        int fs_s;
        int vs_s_low;
        int hs_s_low;

        hs_a_low    = 0;
        rgb_a_lit   = 0;
        first_b_low = -1;
        fs_s        = 0;
        vs_s_low    = 0;
        hs_s_low    = 0;

        applyStimulus(1'b1, 1'b1, COLOR);
        #2;
        checkOutput("rst.a.pix_active",  32'(if_a.pix_active),  32'd0);
        checkOutput("rst.a.frame_start", 32'(if_a.frame_start), 32'd0);
        checkOutput("rst.a.xvga",        32'(if_a.xvga),        32'd0);
        checkOutput("rst.a.hs",          32'(hs_a),             32'd1);
        checkOutput("rst.a.vs",          32'(vs_a),             32'd1);
        checkOutput("rst.a.rgb",         32'(rgb_a),            32'd0);
        checkResetValues("rst0");
        tick();
        tick();
        checkResetValues("rst2");

        @(negedge VGA_CLK);
        applyStimulus(1'b0, 1'b0, COLOR);
        #1;
        $display("[TB] reset released, scanning first line and two small frames");

        for (int c = 0; c < 802; c++) begin
            checkAB(c);
            checkS(c);
            if (c < 800 && !hs_a) hs_a_low++;
            if (c < 800 && rgb_a != 3'b000) rgb_a_lit++;
            if (first_b_low < 0 && !hs_b) first_b_low = c;
            if (c < 2 * S_HTOT * S_VTOT) begin
                if (if_s.frame_start) fs_s++;
                if (!vs_s) vs_s_low++;
                if (!hs_s) hs_s_low++;
            end
            tick();
        end

        checkOutput("a.hs_low_line0",  32'(hs_a_low),    32'd96);
        checkOutput("a.rgb_lit_line0", 32'(rgb_a_lit),   32'd640);
        checkOutput("b.hs_fall_clock", 32'(first_b_low), 32'd660);
        checkOutput("s.frame_starts",  32'(fs_s),        32'd2);
        checkOutput("s.vs_low_clocks", 32'(vs_s_low),    32'd96);
        checkOutput("s.hs_low_clocks", 32'(hs_s_low),    32'd112);

        // Small raster is now on line 5, hcount 10 of its third frame.
        checkOutput("s.mid.pix_active", 32'(if_s.pix_active), 32'd1);
        checkOutput("s.mid.yvga",       32'(if_s.yvga),       32'd1);
        checkOutput("s.mid.xvga",       32'(if_s.xvga),       32'd2);

        applyStimulus(1'b0, 1'b1, COLOR);
        #1;
        checkResetValues("async");
        tick();
        tick();
        tick();
        checkResetValues("held");

        @(negedge VGA_CLK);
        applyStimulus(1'b0, 1'b0, COLOR);
        #1;
        for (int c = 0; c <= S_HTOT * S_VTOT + 2; c++) begin
            checkS(c);
            tick();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 25 MHz VGA_CLK. Drives downscaled 160x120 scan coordinates (xvga, yvga) to the sprite/compositor blocks. Registers their returned 3-bit colour into blanked RGB and sync outputs, delay-matched to the compositor pipeline. It is the producer end of the xvga/yvga interface that display_sprite consumes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_SHIFT, 2, log2 of the downscale factor (4x4 native pixels per game pixel)
PIPE_DELAY, 1, compositor latency in clocks from xvga/yvga to color_in; range 1..4

Ports:
VGA_CLK  input  1  pixel clock, 25 MHz
reset  input  1  asynchronous, active-high
color_in  input  3  compositor colour for the coordinate issued PIPE_DELAY clocks earlier
xvga  output  8  game-pixel column, 0..159
yvga  output  7  game-pixel row, 0..119
pix_active  output  1  current xvga/yvga lies in the visible region
frame_start  output  1  one-clock pulse at hcount=0, vcount=0
vga_hs  output  1  hsync, active-low, delay-matched
vga_vs  output  1  vsync, active-low, delay-matched
vga_rgb  output  3  {R,G,B}; 0 when blanked, delay-matched

Behaviour:
- Counters: hcount 10 b, 0..H_TOTAL-1 (H_TOTAL=800). vcount 10 b, 0..V_TOTAL-1 (V_TOTAL=525). Both are registers.
- Counter stepping: hcount increments every clock. At H_TOTAL-1 it wraps to 0 and vcount increments. At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0 on the same edge.
- Reset: asserting reset forces both counters to 0 immediately. It also clears all delay-line stages to the inactive state. Reset mid-frame abandons the frame; there is no partial-line completion.
- While reset is high:
  - pix_active=0, frame_start=0, xvga=0, yvga=0
  - vga_hs=1, vga_vs=1, vga_rgb=0
- The first clock after reset deassertion presents hcount=0, vcount=0.
- Zero-latency decode from the counters (combinational from registers, no extra flop):
  - active_raw = (hcount<H_ACTIVE) && (vcount<V_ACTIVE)
  - xvga = hcount>>SCALE_SHIFT when hcount<H_ACTIVE, else 0
  - yvga = vcount>>SCALE_SHIFT when vcount<V_ACTIVE, else 0
  - pix_active = active_raw
  - frame_start = (hcount==0 && vcount==0)
  - Each xvga value is held for exactly 4 clocks; each yvga value is held for exactly 4 lines.
- Sync decode:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vs_raw = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
- Delay line: hs_raw, vs_raw and active_raw pass through a PIPE_DELAY-deep shift register. Reset values are hs=1, vs=1, act=0.
- vga_rgb: registered. It takes color_in when the delayed active bit is 1, else 0.
- Alignment: vga_hs, vga_vs and vga_rgb all lag the coordinate by exactly PIPE_DELAY+1 clocks, so sync stays aligned with colour.
- Boundaries:
  - Last visible pixel hcount=639 gives xvga=159.
  - hcount=640 gives xvga=0 and pix_active=0.
  - Line 479 gives yvga=119; line 480 gives yvga=0 and pix_active=0 for the whole vertical blank.
- No back-pressure: colour arriving while blanked is discarded.

Decomposition:
- Package vga_pkg:
  - timing constants (H_/V_ values, H_TOTAL, V_TOTAL)
  - GAME_W=160, GAME_H=120
  - colour width 3 and the colour-code constants shared with display_sprite
- One sub-module, sync_delay_line (parameter DEPTH, reset value per bit), reused for hs, vs and active.
- Counter logic stays in the top module.

Test Plan:
- Reset, then run 800 clocks → xvga steps 0,0,0,0,1,… reaching 159 at hcount 636..639. xvga=0 and pix_active=0 for hcount 640..799.
- Full frame of 420000 clocks → exactly one frame_start pulse per 420000 clocks. vga_vs low for exactly 1600 clocks (lines 490–491). vga_hs low for 96 clocks on each of 525 lines.
- color_in=3'b101 constant, PIPE_DELAY=1 → vga_rgb=3'b101 exactly when pix_active was 1 two clocks earlier, else 0. The first visible rgb appears 2 clocks after frame_start.
- PIPE_DELAY=3 → the hsync falling edge appears 4 clocks after hcount=656. The rgb/active edges shift identically.
- Assert reset at hcount=300, vcount=200 for 3 clocks → outputs take reset values asynchronously. After release, frame_start fires on the first clock and counting restarts from (0,0).
- yvga check → yvga=119 through lines 476..479 and 0 at line 480. The y wrap at line 524→0 coincides with the x wrap.
